// File: rtl/spi_wb_sequencer.sv
// spi_wb_sequencer
// Wishbone master sitting in front of the simple_spi_top register block
// (SPCR=0, SPSR=1, SPDR=2, SPER=3). After reset it programs SPCR and SPER once.
// After that, each byte taken from the tx stream becomes one full SPI transfer:
// write SPDR, poll SPSR until RFEMPTY (bit 0) clears, then read SPDR. The byte
// read back is offered on the rx stream. Only one byte is in flight at a time.
//
// Optional feature: define SPI_SEQ_TIMEOUT_EN to abort a transfer after
// TIMEOUT_POLLS SPSR reads that all report RFEMPTY=1. An abort pulses err_o for
// one cycle, produces no rx byte and returns to idle. When the macro is not
// defined, err_o is tied to 0.
//
// Ports
//   clk_i, rst_i           clock (rising edge); asynchronous reset, active low
//   tx_valid_i/tx_ready_o  tx byte handshake; tx_data_i carries the byte
//   rx_valid_o/rx_ready_i  rx byte handshake; rx_data_o carries the byte
//   busy_o                 high whenever the sequencer is not idle
//   err_o                  one-cycle pulse on poll timeout
//   wb_*                   Wishbone master (2-bit address, 8-bit data)

module spi_wb_sequencer #(
    parameter logic [7:0]  SPCR_INIT     = 8'h50,
    parameter logic [7:0]  SPER_INIT     = 8'h00
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_POLLS = 1024
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       err_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [1:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    localparam logic [1:0] AdrSpcr = 2'd0;
    localparam logic [1:0] AdrSpsr = 2'd1;
    localparam logic [1:0] AdrSpdr = 2'd2;
    localparam logic [1:0] AdrSper = 2'd3;

    typedef enum logic [2:0] {
        StInitSpcr,
        StInitSper,
        StIdle,
        StWrSpdr,
        StRdSpsr,
        StRdSpdr,
        StOut
    } state_e;

    state_e      state_q;
    logic        cyc_q;
    logic        we_q;
    logic [1:0]  adr_q;
    logic [7:0]  dat_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        tx_ready_q;
    logic        busy_q;
    logic [10:0] poll_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    logic        err_q;
`endif

    // A state whose access is finished has cyc_q low. It starts the next access
    // on the following edge, so there is always one idle bus cycle after an ack.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StInitSpcr;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 2'd0;
            dat_q      <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            poll_q     <= 11'd0;
`ifdef SPI_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
`ifdef SPI_SEQ_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                StInitSpcr: begin
                    busy_q <= 1'b1;
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= AdrSpcr;
                        dat_q <= SPCR_INIT;
                    end else if (wb_ack_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= StInitSper;
                    end
                end
                StInitSper: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= AdrSper;
                        dat_q <= SPER_INIT;
                    end else if (wb_ack_i) begin
                        cyc_q      <= 1'b0;
                        we_q       <= 1'b0;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                StIdle: begin
                    // The SPDR write starts on the accepting edge. The bus
                    // data register holds the tx byte until the write is acked.
                    if (tx_valid_i && tx_ready_q) begin
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cyc_q      <= 1'b1;
                        we_q       <= 1'b1;
                        adr_q      <= AdrSpdr;
                        dat_q      <= tx_data_i;
                        state_q    <= StWrSpdr;
                    end
                end
                StWrSpdr: begin
                    if (cyc_q && wb_ack_i) begin
                        cyc_q   <= 1'b0;
                        we_q    <= 1'b0;
                        poll_q  <= 11'd0;
                        state_q <= StRdSpsr;
                    end
                end
                StRdSpsr: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= AdrSpsr;
                    end else if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        if (!wb_dat_i[0]) begin
                            state_q <= StRdSpdr;
                        end else begin
                            if (poll_q != '1) begin
                                poll_q <= poll_q + 11'd1;
                            end
`ifdef SPI_SEQ_TIMEOUT_EN
                            // This read brings the poll count to the limit.
                            if (32'(poll_q) + 32'd1 >= TIMEOUT_POLLS) begin
                                err_q      <= 1'b1;
                                tx_ready_q <= 1'b1;
                                busy_q     <= 1'b0;
                                state_q    <= StIdle;
                            end
`endif
                        end
                    end
                end
                StRdSpdr: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= AdrSpdr;
                    end else if (wb_ack_i) begin
                        cyc_q      <= 1'b0;
                        rx_data_q  <= wb_dat_i;
                        rx_valid_q <= 1'b1;
                        state_q    <= StOut;
                    end
                end
                StOut: begin
                    if (rx_ready_i) begin
                        rx_valid_q <= 1'b0;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    state_q <= StInitSpcr;
                end
            endcase
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;
    assign busy_o     = busy_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
`ifdef SPI_SEQ_TIMEOUT_EN
    assign err_o      = err_q;
`else
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_wb_sequencer.sv
// Bench for spi_wb_sequencer. It models the expected behaviour at the level of
// whole transfers: each tx byte expands into a list of bus accesses and one
// expected rx byte. The bench also plays the Wishbone slave (random ack delay)
// and drives the tx/rx streams with random gaps and back-pressure.

module tb_spi_wb_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] tx_data_i;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic [7:0] rx_data_o;
    logic       busy_o;
    logic       err_o;
    logic       wb_cyc_o;
    logic       wb_stb_o;
    logic       wb_we_o;
    logic [1:0] wb_adr_o;
    logic [7:0] wb_dat_o;
    logic [7:0] wb_dat_i;
    logic       wb_ack_i;

    spi_wb_sequencer dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_data_i  (tx_data_i),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_o  (rx_data_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit       we;
        bit [1:0] adr;
        bit [7:0] wdat;
        bit [7:0] rdat;
        int       dly;
    } txn_t;

    typedef struct {
        bit [7:0] data;
        int       nbusy;
        bit [7:0] busy_val;
        bit [7:0] ready_val;
        bit [7:0] spdr;
        int       wr_dly;
    } item_t;

    int checks = 0;
    int errors = 0;

    txn_t     exp_q[$];
    txn_t     log_q[$];
    bit [7:0] exp_rx[$];
    item_t    stim_q[$];
    txn_t     cur;
    item_t    item;
    bit       has_item;
    int       wcnt;
    int       init_left;
    bit       inflight;
    bit       rx_pending;
    bit       rx_hold;
    int       gap_pct;

    logic       prev_cyc, prev_we, prev_txv, prev_txr, prev_rxv, prev_rxr;
    logic [1:0] prev_adr;
    logic [7:0] prev_dat, prev_rxd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void push_init();
        exp_q.push_back('{we: 1'b1, adr: 2'd0, wdat: 8'h50, rdat: 8'h00, dly: -1});
        exp_q.push_back('{we: 1'b1, adr: 2'd3, wdat: 8'h00, rdat: 8'h00, dly: -1});
        init_left = 2;
    endfunction

    // One transfer: write SPDR, nbusy SPSR reads with RFEMPTY=1, one with
    // RFEMPTY=0, read SPDR; the SPDR value must come back on the rx stream.
    function automatic void push_item_txns(input item_t it);
        exp_q.push_back('{we: 1'b1, adr: 2'd2, wdat: it.data, rdat: 8'h00, dly: it.wr_dly});
        for (int i = 0; i < it.nbusy; i++)
            exp_q.push_back('{we: 1'b0, adr: 2'd1, wdat: 8'h00, rdat: it.busy_val, dly: -1});
        exp_q.push_back('{we: 1'b0, adr: 2'd1, wdat: 8'h00, rdat: it.ready_val, dly: -1});
        exp_q.push_back('{we: 1'b0, adr: 2'd2, wdat: 8'h00, rdat: it.spdr, dly: -1});
        exp_rx.push_back(it.spdr);
    endfunction

    function automatic item_t rand_item();
        item_t it;
        it.data      = 8'($urandom);
        it.nbusy     = int'($urandom_range(0, 3));
        it.busy_val  = 8'($urandom) | 8'h01;
        it.ready_val = 8'($urandom) & 8'hFE;
        it.spdr      = 8'($urandom);
        it.wr_dly    = -1;
        return it;
    endfunction

    function automatic void flush_model();
        exp_q.delete();
        exp_rx.delete();
        stim_q.delete();
        has_item   = 1'b0;
        inflight   = 1'b0;
        rx_pending = 1'b0;
        push_init();
    endfunction

    // One clock: observe the DUT at the falling edge, update the model, check
    // the outputs, then drive the slave and the streams for the next rising edge.
    task automatic cycle();
        bit exp_ready;
        @(negedge clk_i);
        if (!rst_i) begin
            prev_cyc = 1'b0; prev_we = 1'b0; prev_adr = 2'd0; prev_dat = 8'h00;
            prev_txv = 1'b0; prev_txr = 1'b0; prev_rxv = 1'b0; prev_rxr = 1'b0;
            prev_rxd = 8'h00;
            wb_ack_i   = 1'b0;
            tx_valid_i = 1'b0;
            rx_ready_i = 1'b0;
            wcnt       = 0;
            return;
        end
        if (prev_txv && prev_txr) begin
            push_item_txns(item);
            has_item = 1'b0;
            inflight = 1'b1;
        end
        if (prev_cyc && wb_ack_i) begin
            chk("cyc_drop_after_ack", wb_cyc_o, 0);
            if (init_left > 0) init_left--;
            if (!cur.we && cur.adr == 2'd2) rx_pending = 1'b1;
        end else if (prev_cyc) begin
            chk("cyc_held", wb_cyc_o, 1);
            chk("bus_stable", {wb_we_o, wb_adr_o, wb_dat_o}, {prev_we, prev_adr, prev_dat});
        end
        if (!prev_cyc && wb_cyc_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_txn", {wb_we_o, wb_adr_o, wb_dat_o}, 32'hFFFF_FFFF);
            end else begin
                cur = exp_q.pop_front();
                if (cur.dly < 0) cur.dly = int'($urandom_range(0, 2));
                wcnt = 0;
                chk("txn_we", wb_we_o, cur.we);
                chk("txn_adr", wb_adr_o, cur.adr);
                if (cur.we) chk("txn_wdat", wb_dat_o, cur.wdat);
                log_q.push_back('{we: wb_we_o, adr: wb_adr_o, wdat: wb_dat_o, rdat: cur.rdat,
                                  dly: cur.dly});
            end
        end
        if (prev_rxv && prev_rxr) begin
            if (exp_rx.size() == 0) chk("unexpected_rx", prev_rxd, 32'hFFFF_FFFF);
            else chk("rx_data_handshake", prev_rxd, exp_rx.pop_front());
            inflight   = 1'b0;
            rx_pending = 1'b0;
        end else if (prev_rxv) begin
            chk("rx_hold_valid", rx_valid_o, 1);
            chk("rx_hold_data", rx_data_o, prev_rxd);
        end
        exp_ready = (init_left == 0) && !inflight;
        chk("tx_ready", tx_ready_o, exp_ready);
        chk("busy", busy_o, !exp_ready);
        chk("rx_valid", rx_valid_o, rx_pending);
        if (rx_pending && exp_rx.size() > 0) chk("rx_data", rx_data_o, exp_rx[0]);
        chk("stb_eq_cyc", wb_stb_o, wb_cyc_o);
        chk("err", err_o, 0);

        // Slave: the ack is a one-cycle pulse, and read data is only valid in the ack cycle.
        if (wb_ack_i) begin
            wb_ack_i = 1'b0;
            wb_dat_i = 8'($urandom);
        end else if (wb_cyc_o) begin
            if (wcnt >= cur.dly) begin
                wb_ack_i = 1'b1;
                wb_dat_i = cur.rdat;
            end else begin
                wcnt++;
                wb_dat_i = 8'($urandom);
            end
        end else begin
            wb_dat_i = 8'($urandom);
        end
        if (!has_item && stim_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
            item     = stim_q.pop_front();
            has_item = 1'b1;
        end
        tx_valid_i = has_item;
        tx_data_i  = has_item ? item.data : 8'($urandom);
        rx_ready_i = rx_hold ? 1'b0 : 1'($urandom_range(0, 1));

        prev_cyc = wb_cyc_o; prev_we = wb_we_o; prev_adr = wb_adr_o; prev_dat = wb_dat_o;
        prev_txv = tx_valid_i; prev_txr = tx_ready_o;
        prev_rxv = rx_valid_o; prev_rxr = rx_ready_i; prev_rxd = rx_data_o;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (stim_q.size() == 0 && !has_item && !inflight && init_left == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, done, 1);
    endtask

    initial begin
        int  spsr_reads;
        int  mark;
        bit  seen;
        item_t it;

        rst_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'h00; rx_ready_i = 1'b0;
        wb_dat_i = 8'h00; wb_ack_i = 1'b0;
        rx_hold = 1'b1; gap_pct = 0; has_item = 1'b0; wcnt = 0;
        prev_cyc = 1'b0; prev_txv = 1'b0; prev_rxv = 1'b0;
        flush_model();

        // Directed: A5 is already pending while init runs; SPSR reads 05, 05, 04; SPDR is 3C.
        stim_q.push_back('{data: 8'hA5, nbusy: 2, busy_val: 8'h05, ready_val: 8'h04,
                           spdr: 8'h3C, wr_dly: -1});
        it = rand_item();
        it.data = 8'hA5; it.wr_dly = 5;
        stim_q.push_back(it);

        #2;
        chk("rst_tx_ready", tx_ready_o, 0);
        chk("rst_rx_valid", rx_valid_o, 0);
        chk("rst_rx_data", rx_data_o, 8'h00);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 8'h00);
        cycle();
        cycle();
        #2 rst_i = 1'b1;

        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (rx_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk("first_rx_timeout", seen, 1);
        chk("init0_we", log_q[0].we, 1);
        chk("init0_adr", log_q[0].adr, 0);
        chk("init0_dat", log_q[0].wdat, 8'h50);
        chk("init1_we", log_q[1].we, 1);
        chk("init1_adr", log_q[1].adr, 3);
        chk("init1_dat", log_q[1].wdat, 8'h00);
        chk("spdr_write_dat", log_q[2].wdat, 8'hA5);
        spsr_reads = 0;
        foreach (log_q[i]) if (!log_q[i].we && log_q[i].adr == 2'd1) spsr_reads++;
        chk("spsr_read_count", spsr_reads, 3);
        chk("first_rx_data", rx_data_o, 8'h3C);

        // Consumer stalls for 10 cycles while the next byte is already offered.
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_rx_valid", rx_valid_o, 1);
            chk("stall_rx_data", rx_data_o, 8'h3C);
            chk("stall_tx_ready", tx_ready_o, 0);
            chk("stall_tx_valid_offered", tx_valid_i, 1);
        end
        rx_hold = 1'b0;

        // The second byte's SPDR write is acked 5 cycles late.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (wb_cyc_o && wb_we_o && wb_adr_o == 2'd2) begin
                seen = 1'b1;
                break;
            end
        end
        chk("slow_write_timeout", seen, 1);
        for (int i = 0; i < 5; i++) begin
            chk("slow_write_cyc", wb_cyc_o, 1);
            chk("slow_write_we", wb_we_o, 1);
            chk("slow_write_adr", wb_adr_o, 2);
            chk("slow_write_dat", wb_dat_o, 8'hA5);
            cycle();
        end
        wait_idle("directed_idle_timeout", 500);

        // Random traffic with gaps on tx, random back-pressure on rx and random ack delays.
        gap_pct = 30;
        for (int i = 0; i < 40; i++) stim_q.push_back(rand_item());
        wait_idle("random_idle_timeout", 20000);

        // Reset while the sequencer is polling SPSR.
        it = rand_item();
        it.nbusy = 5; it.busy_val = 8'h05;
        stim_q.push_back(it);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (wb_cyc_o && !wb_we_o && wb_adr_o == 2'd1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("poll_reach_timeout", seen, 1);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_cyc", wb_cyc_o, 0);
        chk("midrst_stb", wb_stb_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_tx_ready", tx_ready_o, 0);
        chk("midrst_rx_valid", rx_valid_o, 0);
        flush_model();
        mark = log_q.size();
        cycle();
        cycle();
        #2 rst_i = 1'b1;
        for (int i = 0; i < 10; i++) stim_q.push_back(rand_item());
        wait_idle("post_reset_idle_timeout", 5000);
        chk("reinit0_adr", log_q[mark].adr, 0);
        chk("reinit0_dat", log_q[mark].wdat, 8'h50);
        chk("reinit1_adr", log_q[mark + 1].adr, 3);
        chk("reinit1_dat", log_q[mark + 1].wdat, 8'h00);
        for (int i = 0; i < 5; i++) cycle();
        chk("exp_txn_left", exp_q.size(), 0);
        chk("exp_rx_left", exp_rx.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
